// File: rtl/bram_line_reader_pkg.sv
// Shared defaults and the read-credit helper for the BRAM line reader.
package bram_line_reader_pkg;

   localparam int DEF_BITS      = 32;
   localparam int DEF_ADD_WIDTH = 9;

   // Words already owed to the skid FIFO once this cycle's pop is accounted for.
   function automatic logic [2:0] credit_level(input logic [1:0] fifo_count,
                                               input logic       pending,
                                               input logic       pop);
      credit_level = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry skid FIFO holding {last, data}; simultaneous push and pop allowed.
module bram_skid_fifo
#(
   parameter int W = 33
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o,
   output logic         valid_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/bram_line_reader.sv
// Sequential BRAM read initiator presenting the words as a ready/valid stream.
// Stream handshake: a beat moves when out_valid & out_ready; data/last hold while stalled.
module bram_line_reader
   import bram_line_reader_pkg::*;
#(
   parameter int Bits      = DEF_BITS,
   parameter int Add_Width = DEF_ADD_WIDTH
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [Add_Width-1:0] base_addr,
   input  logic [Add_Width:0]   len,
   output logic                 busy,
   output logic                 done,
   output logic [Add_Width-1:0] mem_addr,
   output logic                 mem_cen,
   output logic                 mem_wen,
   input  logic [Bits-1:0]      mem_rdata,
   output logic [Bits-1:0]      out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [0:0]           state_dbg
);

   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_RUN  = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [Add_Width-1:0] rd_ptr_q, rd_ptr_d;
   logic [Add_Width:0]   remaining_q, remaining_d;
   logic                 pending_q, pending_d;
   logic                 pending_last_q, pending_last_d;
   logic                 done_q, done_d;

   logic                 pop;
   logic                 issue;
   logic [2:0]           credit;
   logic [Bits:0]        fifo_head;
   logic [1:0]           fifo_count;
   logic                 fifo_valid;

   assign pop    = fifo_valid & out_ready;
   assign credit = credit_level(fifo_count, pending_q, pop);
   // A read is only launched when its word is guaranteed a FIFO slot on arrival.
   assign issue  = (state_q == STATE_RUN) && (remaining_q != '0) && (credit < 3'd2);

   always_comb begin
      state_d        = state_q;
      rd_ptr_d       = rd_ptr_q;
      remaining_d    = remaining_q;
      done_d         = 1'b0;
      pending_d      = issue;
      pending_last_d = issue && (remaining_q == (Add_Width+1)'(1));
      case (state_q)
         STATE_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = STATE_RUN;
                  rd_ptr_d    = base_addr;
                  remaining_d = len;
               end
            end
         end
         STATE_RUN: begin
            if (issue) begin
               rd_ptr_d    = rd_ptr_q + Add_Width'(1);
               remaining_d = remaining_q - (Add_Width+1)'(1);
            end
            if (pop && fifo_head[Bits]) begin
               state_d = STATE_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= STATE_IDLE;
         rd_ptr_q       <= '0;
         remaining_q    <= '0;
         pending_q      <= 1'b0;
         pending_last_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         remaining_q    <= remaining_d;
         pending_q      <= pending_d;
         pending_last_q <= pending_last_d;
         done_q         <= done_d;
      end
   end

   // mem_rdata is only trusted in the cycle after a read strobe.
   bram_skid_fifo #(.W(Bits + 1)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (pending_q),
      .push_data_i ({pending_last_q, mem_rdata}),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .valid_o     (fifo_valid)
   );

   assign mem_cen   = issue;
   assign mem_addr  = rd_ptr_q;
   assign mem_wen   = 1'b0;
   assign busy      = (state_q == STATE_RUN);
   assign done      = done_q;
   assign out_valid = fifo_valid;
   assign out_data  = fifo_head[Bits-1:0];
   assign out_last  = fifo_valid & fifo_head[Bits];
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bram_line_reader.sv
// Bench for bram_line_reader: BRAM model with garbage on idle cycles plus a stream scoreboard.
module tb_bram_line_reader;

   localparam int BITS  = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic            clk;
   logic            rst;
   logic            start;
   logic [AW-1:0]   base_addr;
   logic [AW:0]     len;
   logic            busy;
   logic            done;
   logic [AW-1:0]   mem_addr;
   logic            mem_cen;
   logic            mem_wen;
   logic [BITS-1:0] mem_rdata;
   logic [BITS-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic [0:0]      state_dbg;

   bram_line_reader #(.Bits(BITS), .Add_Width(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_cen   (mem_cen),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // buffer model: ram[i] = i, random garbage (top bit set) when not read
   logic [BITS-1:0] ram [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = BITS'(i);
   end
   always @(posedge clk) begin
      if (mem_cen && !mem_wen) mem_rdata <= ram[mem_addr];
      else                     mem_rdata <= $urandom() | 32'h8000_0000;
   end

   // scoreboard state
   int checks = 0;
   int errors = 0;
   logic [BITS:0]   exp_q[$];
   logic [AW-1:0]   exp_addr_q[$];
   int issued   = 0;
   int popped   = 0;
   int done_cnt = 0;
   int pattern [6] = '{1, 0, 0, 1, 0, 1};

   // monitor: samples on the falling edge
   initial begin
      logic            prev_stall;
      logic [BITS-1:0] prev_data;
      logic            prev_last;
      logic            pop_now;
      logic [BITS:0]   e;
      logic [AW-1:0]   ea;
      int              occ;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            pop_now = out_valid && out_ready;
            occ     = issued - popped;
            checks++;
            if (mem_wen !== 1'b0) begin
               errors++; $display("FAIL wen: got %b want 0", mem_wen);
            end
            if (mem_cen === 1'b1) begin
               checks++;
               if (occ - int'(pop_now) >= 2) begin
                  errors++; $display("FAIL credit: read issued with occupancy %0d pop %0d", occ, pop_now);
               end
               checks++;
               if (exp_addr_q.size() == 0) begin
                  errors++; $display("FAIL read_addr: unexpected read at addr %0d", mem_addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (mem_addr !== ea) begin
                     errors++; $display("FAIL read_addr: got %0d want %0d", mem_addr, ea);
                  end
               end
               issued++;
            end
            if (prev_stall) begin
               checks++;
               if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                           out_valid, out_data, out_last, prev_data, prev_last);
               end
            end
            if (pop_now) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL beat: unexpected beat d=%h l=%b", out_data, out_last);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_last, out_data} !== e) begin
                     errors++;
                     $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                              out_data, out_last, e[BITS-1:0], e[BITS]);
                  end
               end
               popped++;
            end
            if (done === 1'b1) begin
               done_cnt++;
               checks++;
               if (busy !== 1'b0) begin
                  errors++; $display("FAIL done_busy: busy=%b during done", busy);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
         end
      end
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expect(input int b, input int n);
      int a;
      for (int k = 0; k < n; k++) begin
         a = (b + k) % DEPTH;
         exp_addr_q.push_back(a[AW-1:0]);
         exp_q.push_back({(k == n - 1), ram[a]});
      end
   endtask

   task automatic start_xfer(input int b, input int n, input bit accepted);
      start     = 1'b1;
      base_addr = b[AW-1:0];
      len       = n[AW:0];
      if (accepted) push_expect(b, n);
      tick();
      start = 1'b0;
   endtask

   // returns positioned inside the done cycle
   task automatic run_until_done(input int mode, input int budget, input string name);
      bit ok;
      int k;
      ok = 1'b0;
      k  = 0;
      repeat (budget) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pattern[k % 6][0];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
         tick();
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if ({busy, done, mem_cen, mem_wen, out_valid, out_last} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b done=%b cen=%b wen=%b valid=%b last=%b want all 0",
                  busy, done, mem_cen, mem_wen, out_valid, out_last);
      end
      checks++;
      if (mem_addr !== '0 || out_data !== '0) begin
         errors++; $display("FAIL reset_data: got addr=%0d data=%h want 0 0", mem_addr, out_data);
      end
      tick();
      tick();
      #2 rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || mem_cen !== 1'b0) begin
         errors++; $display("FAIL reset_release: got busy=%b valid=%b cen=%b want 0", busy, out_valid, mem_cen);
      end
   endtask

   task automatic test_basic();
      bit              e_cen, e_valid, e_last, e_done, e_busy;
      logic [AW-1:0]   e_addr;
      logic [BITS-1:0] e_data;
      out_ready = 1'b1;
      start_xfer(5, 4, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         e_cen   = (k >= 1 && k <= 4);
         e_addr  = AW'(5 + k - 1);
         e_valid = (k >= 3 && k <= 6);
         e_data  = BITS'(5 + k - 3);
         e_last  = (k == 6);
         e_done  = (k == 7);
         e_busy  = (k <= 6);
         checks++;
         if (mem_cen !== e_cen || (e_cen && mem_addr !== e_addr)) begin
            errors++; $display("FAIL basic_read c%0d: got cen=%b addr=%0d want cen=%b addr=%0d",
                               k, mem_cen, mem_addr, e_cen, e_addr);
         end
         checks++;
         if (out_valid !== e_valid || (e_valid && (out_data !== e_data || out_last !== e_last))) begin
            errors++; $display("FAIL basic_out c%0d: got v=%b d=%h l=%b want v=%b d=%h l=%b",
                               k, out_valid, out_data, out_last, e_valid, e_data, e_last);
         end
         checks++;
         if (done !== e_done || busy !== e_busy) begin
            errors++; $display("FAIL basic_status c%0d: got done=%b busy=%b want done=%b busy=%b",
                               k, done, busy, e_done, e_busy);
         end
      end
      tick();
   endtask

   task automatic test_wrap();
      start_xfer(14, 4, 1'b1);
      run_until_done(0, 50, "wrap");
      tick();
   endtask

   task automatic test_backpressure();
      int p0;
      p0 = popped;
      start_xfer(0, 6, 1'b1);
      run_until_done(1, 200, "bp");
      tick();
      checks++;
      if (popped - p0 !== 6) begin
         errors++; $display("FAIL bp_count: got %0d beats want 6", popped - p0);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_len_zero();
      int d0, i0;
      d0 = done_cnt;
      i0 = issued;
      start_xfer(7, 0, 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || mem_cen !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL len0_cycle: got done=%b busy=%b cen=%b valid=%b want 1 0 0 0",
                            done, busy, mem_cen, out_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || done_cnt - d0 !== 1 || issued !== i0) begin
         errors++; $display("FAIL len0_after: got done=%b dones=%0d reads=%0d want 0 1 0",
                            done, done_cnt - d0, issued - i0);
      end
   endtask

   task automatic test_len_depth();
      int d0, p0;
      d0 = done_cnt;
      p0 = popped;
      start_xfer(3, DEPTH, 1'b1);
      run_until_done(2, 400, "depth");
      tick();
      checks++;
      if (popped - p0 !== DEPTH || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL depth_count: got beats=%0d dones=%0d want %0d 1",
                            popped - p0, done_cnt - d0, DEPTH);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      int d0, p0;
      d0 = done_cnt;
      p0 = popped;
      out_ready = 1'b1;
      start_xfer(0, 3, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL b2b_busy: got busy=%b want 1", busy);
      end
      start_xfer(9, 5, 1'b0);
      run_until_done(0, 50, "b2b_first");
      start_xfer(2, 3, 1'b1);
      run_until_done(2, 100, "b2b_second");
      tick();
      checks++;
      if (done_cnt - d0 !== 2 || popped - p0 !== 6) begin
         errors++; $display("FAIL b2b_count: got dones=%0d beats=%0d want 2 6",
                            done_cnt - d0, popped - p0);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      int p0, d0;
      bit hit;
      out_ready = 1'b1;
      p0  = popped;
      hit = 1'b0;
      start_xfer(0, 8, 1'b1);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (popped - p0 == 1) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit || out_valid !== 1'b1) begin
         errors++; $display("FAIL rstmid_beat2: got hit=%b valid=%b want 1 1", hit, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, mem_cen, out_valid, out_last} !== 5'b0 || out_data !== '0 || mem_addr !== '0) begin
         errors++; $display("FAIL rstmid_outputs: got busy=%b done=%b cen=%b valid=%b last=%b d=%h a=%0d want 0",
                            busy, done, mem_cen, out_valid, out_last, out_data, mem_addr);
      end
      exp_q.delete();
      exp_addr_q.delete();
      issued = 0;
      popped = 0;
      @(posedge clk);
      #3 rst = 1'b0;
      d0 = done_cnt;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || mem_cen !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: got valid=%b cen=%b busy=%b want 0", out_valid, mem_cen, busy);
         end
      end
      checks++;
      if (done_cnt !== d0) begin
         errors++; $display("FAIL rstmid_done: got %0d extra done pulses want 0", done_cnt - d0);
      end
      start_xfer(4, 5, 1'b1);
      run_until_done(2, 100, "rstmid_next");
      tick();
      out_ready = 1'b1;
   endtask

   task automatic test_random();
      int b, n;
      for (int t = 0; t < 8; t++) begin
         b = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, DEPTH);
         start_xfer(b, n, 1'b1);
         run_until_done(2, 300, "random");
         if ($urandom_range(0, 1) == 1) tick();
      end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_len_depth();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (4) tick();
      checks++;
      if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
         errors++; $display("FAIL drain: got %0d beats %0d reads outstanding want 0 0",
                            exp_q.size(), exp_addr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
